// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              write_ok_c;
    logic              read_ok_c;
    logic [CNT_W-1:0]  count_next_c;

    // Acceptance is judged against the flags registered before the edge.
    always_comb begin
        write_ok_c   = w_en & ~full;
        read_ok_c    = r_en & ~empty;
        count_next_c = count;
        unique case ({write_ok_c, read_ok_c})
            2'b10:   count_next_c = count + CNT_W'(1);
            2'b01:   count_next_c = count - CNT_W'(1);
            default: count_next_c = count;
        endcase
    end

    // Storage is never reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (write_ok_c) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Flags are registered from the next count so they track count exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (write_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (read_ok_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next_c;
            full         <= (count_next_c == CNT_W'(DEPTH));
            empty        <= (count_next_c == '0);
            almost_full  <= (count_next_c >= CNT_W'(AF_LEVEL));
            almost_empty <= (count_next_c <= CNT_W'(AE_LEVEL));
            overflow     <= w_en & full;
            underflow    <= r_en & empty;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented without a read; zero while nothing is stored.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else if (read_ok_c) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-mode and an FWFT instance,
// both DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, sharing clock and reset.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_w_en, a_r_en;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_count;

    logic       b_w_en, b_r_en;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .w_en(a_w_en), .r_en(a_r_en), .data_in(a_din),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(b_w_en), .r_en(b_r_en), .data_in(b_din),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_w_en = 1'b0; a_r_en = 1'b0; a_din = 8'h00;
        b_w_en = 1'b0; b_r_en = 1'b0; b_din = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", a_empty); end
        n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", a_full); end
        n_checks++; if (a_af !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", a_af); end
        n_checks++; if (a_ae !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 1", a_ae); end
        n_checks++; if ({a_ovf, a_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_unf: got %b want 00", {a_ovf, a_unf}); end
        n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %0h want 0", a_dout); end
        n_checks++; if (b_dout !== 8'h00) begin n_fail++; $display("FAIL reset_fwft_data_out: got %0h want 0", b_dout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [7:0] vals   [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        logic [2:0] exp_c  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic       exp_ae [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_f  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a_w_en = 1'b1; a_din = vals[i];
            tick();
            n_checks++; if (a_count !== exp_c[i]) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, a_count, exp_c[i]); end
            n_checks++; if (a_ae !== exp_ae[i]) begin n_fail++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, a_ae, exp_ae[i]); end
            n_checks++; if (a_af !== exp_af[i]) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, a_af, exp_af[i]); end
            n_checks++; if (a_full !== exp_f[i]) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, a_full, exp_f[i]); end
        end
        a_din = 8'd50;
        tick();
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_pulse: got %b want 1", a_ovf); end
        n_checks++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d want 4", a_count); end
        a_w_en = 1'b0;
        tick();
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL overflow_one_cycle: got %b want 0", a_ovf); end
    endtask

    task automatic test_drain();
        logic [7:0] exp_d [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        a_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (a_dout !== exp_d[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %0d want %0d", i, a_dout, exp_d[i]); end
        end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", a_empty); end
        tick();
        n_checks++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse: got %b want 1", a_unf); end
        n_checks++; if (a_dout !== 8'd40) begin n_fail++; $display("FAIL underflow_hold: got %0d want 40", a_dout); end
        a_r_en = 1'b0;
        tick();
        n_checks++; if (a_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_one_cycle: got %b want 0", a_unf); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d [4] = '{8'd3, 8'd4, 8'd5, 8'd6};
        for (int i = 1; i <= 3; i++) begin
            a_w_en = 1'b1; a_din = 8'(i);
            tick();
        end
        a_w_en = 1'b0; a_r_en = 1'b1;
        tick();
        n_checks++; if (a_dout !== 8'd1) begin n_fail++; $display("FAIL wrap_read1: got %0d want 1", a_dout); end
        tick();
        n_checks++; if (a_dout !== 8'd2) begin n_fail++; $display("FAIL wrap_read2: got %0d want 2", a_dout); end
        a_r_en = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            a_w_en = 1'b1; a_din = 8'(i);
            tick();
        end
        a_w_en = 1'b0;
        n_checks++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL wrap_peak_count: got %0d want 4", a_count); end
        n_checks++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %b want 1", a_full); end
        a_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (a_dout !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, a_dout, exp_d[i]); end
        end
        a_r_en = 1'b0;
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", a_empty); end
    endtask

    task automatic test_simultaneous();
        a_w_en = 1'b1; a_din = 8'd7; tick();
        a_din = 8'd8; tick();
        a_r_en = 1'b1; a_din = 8'd9;
        tick();
        n_checks++; if (a_count !== 3'd2) begin n_fail++; $display("FAIL simul_mid_count: got %0d want 2", a_count); end
        n_checks++; if (a_dout !== 8'd7) begin n_fail++; $display("FAIL simul_mid_data: got %0d want 7", a_dout); end
        a_r_en = 1'b0;
        a_din = 8'd10; tick();
        a_din = 8'd11; tick();
        n_checks++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL simul_prefull: got %b want 1", a_full); end
        a_r_en = 1'b1; a_din = 8'd12;
        tick();
        n_checks++; if (a_count !== 3'd3) begin n_fail++; $display("FAIL simul_full_count: got %0d want 3", a_count); end
        n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL simul_full_overflow: got %b want 1", a_ovf); end
        n_checks++; if (a_dout !== 8'd8) begin n_fail++; $display("FAIL simul_full_data: got %0d want 8", a_dout); end
        a_w_en = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (a_dout !== 8'd11) begin n_fail++; $display("FAIL simul_drain_data: got %0d want 11", a_dout); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL simul_drain_empty: got %b want 1", a_empty); end
        a_w_en = 1'b1; a_din = 8'd13;
        tick();
        n_checks++; if (a_count !== 3'd1) begin n_fail++; $display("FAIL simul_empty_count: got %0d want 1", a_count); end
        n_checks++; if (a_unf !== 1'b1) begin n_fail++; $display("FAIL simul_empty_underflow: got %b want 1", a_unf); end
        n_checks++; if (a_dout !== 8'd11) begin n_fail++; $display("FAIL simul_empty_hold: got %0d want 11", a_dout); end
        a_w_en = 1'b0; a_r_en = 1'b0;
        tick();
        a_r_en = 1'b1;
        tick();
        a_r_en = 1'b0;
        n_checks++; if (a_dout !== 8'd13) begin n_fail++; $display("FAIL simul_empty_later_read: got %0d want 13", a_dout); end
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL simul_final_count: got %0d want 0", a_count); end
    endtask

    task automatic test_fwft();
        b_w_en = 1'b1; b_din = 8'hA5;
        tick();
        n_checks++; if (b_dout !== 8'hA5) begin n_fail++; $display("FAIL fwft_head_first: got %0h want a5", b_dout); end
        n_checks++; if (b_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_not_empty: got %b want 0", b_empty); end
        b_din = 8'h3C;
        tick();
        b_w_en = 1'b0;
        n_checks++; if (b_dout !== 8'hA5) begin n_fail++; $display("FAIL fwft_head_stable: got %0h want a5", b_dout); end
        n_checks++; if (b_count !== 3'd2) begin n_fail++; $display("FAIL fwft_count: got %0d want 2", b_count); end
        b_r_en = 1'b1;
        tick();
        n_checks++; if (b_dout !== 8'h3C) begin n_fail++; $display("FAIL fwft_pop1: got %0h want 3c", b_dout); end
        tick();
        b_r_en = 1'b0;
        n_checks++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop2_empty: got %b want 1", b_empty); end
        n_checks++; if (b_dout !== 8'h00) begin n_fail++; $display("FAIL fwft_empty_zero: got %0h want 0", b_dout); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 4; i++) begin
            a_w_en = 1'b1; a_din = 8'(21 + i);
            tick();
        end
        a_w_en = 1'b0; a_r_en = 1'b1;
        tick();
        a_r_en = 1'b0;
        n_checks++; if (a_count !== 3'd3) begin n_fail++; $display("FAIL midrst_precount: got %0d want 3", a_count); end
        n_checks++; if (a_dout !== 8'd21) begin n_fail++; $display("FAIL midrst_predata: got %0d want 21", a_dout); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", a_count); end
        n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: got %b want 1", a_empty); end
        n_checks++; if (a_dout !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %0h want 0", a_dout); end
        n_checks++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got %b want 0", a_full); end
        #1;
        rst = 1'b0;
        tick();
        a_w_en = 1'b1; a_din = 8'h55;
        tick();
        a_w_en = 1'b0; a_r_en = 1'b1;
        tick();
        a_r_en = 1'b0;
        n_checks++; if (a_dout !== 8'h55) begin n_fail++; $display("FAIL midrst_roundtrip: got %0h want 55", a_dout); end
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL midrst_after_count: got %0d want 0", a_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
